// File: rtl/calc_pkg.sv
// Shared definitions for the calculator command sequencer: opcodes,
// result status codes and the sequencer state encoding.
package calc_pkg;

  // ALU opcodes; anything above OP_MOD is not an ALU operation.
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_MUL = 4'd5;
  localparam logic [3:0] OP_DIV = 4'd6;
  localparam logic [3:0] OP_MOD = 4'd7;

  // Status codes reported alongside both result bytes.
  localparam logic [1:0] STAT_OK      = 2'd0;
  localparam logic [1:0] STAT_ALU_ERR = 2'd1;
  localparam logic [1:0] STAT_INVALID = 2'd2;
  localparam logic [1:0] STAT_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_LD_A   = 3'd0,
    S_LD_B   = 3'd1,
    S_LD_OP  = 3'd2,
    S_ISSUE  = 3'd3,
    S_WAIT   = 3'd4,
    S_OUT_LO = 3'd5,
    S_OUT_HI = 3'd6
  } state_t;

  function automatic logic op_is_valid(input logic [3:0] op);
    return op <= OP_MOD;
  endfunction

endpackage

// File: rtl/calc_timeout_ctr.sv
// WAIT-phase cycle counter: counts up from zero while enabled and flags
// the terminal count TIMEOUT-1. It parks at the terminal count until cleared.
module calc_timeout_ctr #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  // Count WAIT cycles; clear has priority over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (clr)
      r_cnt <= '0;
    else if (en && !tc)
      r_cnt <= r_cnt + CW'(1);
  end

  assign tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/calc_sequencer.sv
// Command sequencer in front of the shared ALU: collects A, B and opcode
// bytes, issues one ALU operation, waits for completion (with timeout) and
// returns the 16-bit result as a low byte followed by a high byte.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   S_LD_A   | idle, waiting for operand A byte
//   S_LD_B   | waiting for operand B byte
//   S_LD_OP  | waiting for opcode byte; invalid ops skip the ALU
//   S_ISSUE  | alu_start pulse cycle
//   S_WAIT   | waiting for alu_done, timeout counter running
//   S_OUT_LO | presenting result[7:0]
//   S_OUT_HI | presenting result[15:8] with res_last
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int W       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  input  logic           clr,
  input  logic [W-1:0]   in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic           alu_start,
  output logic [3:0]     alu_op,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  input  logic           alu_done,
  input  logic [2*W-1:0] alu_result,
  input  logic           alu_err,
  output logic [W-1:0]   res_data,
  output logic           res_valid,
  output logic           res_last,
  output logic [1:0]     res_err,
  input  logic           res_ready,
  output logic           busy
);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_a_buf, r_b_buf;
  logic [W-1:0]   r_alu_a, r_alu_b;
  logic [3:0]     r_alu_op;
  logic           r_alu_start;
  logic [2*W-1:0] r_result, w_result_nxt;
  logic [1:0]     r_res_err, w_err_nxt;
  logic [W-1:0]   r_res_data;
  logic           r_res_valid, r_res_last, r_busy;
  logic           w_accept, w_out_hs, w_tc;
  logic           w_ld_a, w_ld_b, w_ld_op;

  assign in_ready = ena && (r_state == S_LD_A || r_state == S_LD_B || r_state == S_LD_OP);
  assign w_accept = in_valid && in_ready;
  assign w_out_hs = r_res_valid && res_ready;
  assign w_ld_a   = w_accept && !clr && (r_state == S_LD_A);
  assign w_ld_b   = w_accept && !clr && (r_state == S_LD_B);
  assign w_ld_op  = w_accept && !clr && (r_state == S_LD_OP);

  calc_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr || (r_state != S_WAIT)),
    .en    (r_state == S_WAIT),
    .tc    (w_tc)
  );

  // Next state plus the result/status to be latched; clr overrides everything.
  always_comb begin
    w_state_nxt  = r_state;
    w_result_nxt = r_result;
    w_err_nxt    = r_res_err;
    case (r_state)
      S_LD_A:  if (w_accept) w_state_nxt = S_LD_B;
      S_LD_B:  if (w_accept) w_state_nxt = S_LD_OP;
      S_LD_OP: begin
        if (w_accept) begin
          if (op_is_valid(in_data[3:0])) begin
            w_state_nxt = S_ISSUE;
          end else begin
            w_state_nxt  = S_OUT_LO;
            w_result_nxt = '1;
            w_err_nxt    = STAT_INVALID;
          end
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (alu_done) begin
          w_state_nxt  = S_OUT_LO;
          w_result_nxt = alu_result;
          w_err_nxt    = alu_err ? STAT_ALU_ERR : STAT_OK;
        end else if (w_tc) begin
          w_state_nxt  = S_OUT_LO;
          w_result_nxt = '1;
          w_err_nxt    = STAT_TIMEOUT;
        end
      end
      S_OUT_LO: if (w_out_hs) w_state_nxt = S_OUT_HI;
      S_OUT_HI: if (w_out_hs) w_state_nxt = S_LD_A;
      default:  w_state_nxt = S_LD_A;
    endcase
    if (clr) begin
      w_state_nxt  = S_LD_A;
      w_result_nxt = r_result;
      w_err_nxt    = r_res_err;
    end
  end

  // State, operand capture and registered outputs derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_LD_A;
      r_a_buf     <= '0;
      r_b_buf     <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_alu_start <= 1'b0;
      r_result    <= '0;
      r_res_err   <= '0;
      r_res_data  <= '0;
      r_res_valid <= 1'b0;
      r_res_last  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_result  <= w_result_nxt;
      r_res_err <= w_err_nxt;
      if (w_ld_a) r_a_buf <= in_data;
      if (w_ld_b) r_b_buf <= in_data;
      // ALU operands only change on an opcode accept so they stay stable
      // through ISSUE/WAIT/OUT and while the next command is being loaded.
      if (w_ld_op) begin
        r_alu_a  <= r_a_buf;
        r_alu_b  <= r_b_buf;
        r_alu_op <= in_data[3:0];
      end
      r_alu_start <= (w_state_nxt == S_ISSUE);
      r_res_valid <= (w_state_nxt == S_OUT_LO) || (w_state_nxt == S_OUT_HI);
      r_res_last  <= (w_state_nxt == S_OUT_HI);
      r_busy      <= (w_state_nxt != S_LD_A);
      if (w_state_nxt == S_OUT_HI)
        r_res_data <= w_result_nxt[2*W-1:W];
      else if (w_state_nxt == S_OUT_LO)
        r_res_data <= w_result_nxt[W-1:0];
      else
        r_res_data <= '0;
    end
  end

  assign alu_start = r_alu_start;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_op    = r_alu_op;
  assign res_data  = r_res_data;
  assign res_valid = r_res_valid;
  assign res_last  = r_res_last;
  assign res_err   = r_res_err;
  assign busy      = r_busy;

endmodule
